// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES control path.
// Provides the key-size mode code and the default geometry of the mode FIFO.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_AES128 = 2'd0,
    MODE_AES192 = 2'd1,
    MODE_AES256 = 2'd2,
    MODE_NONE   = 2'd3
  } aes_mode_e;

  localparam int FIFO_WIDTH = $bits(aes_mode_e);
  localparam int FIFO_DEPTH = 5;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: circular buffer pointer that wraps DEPTH-1 -> 0.
// DEPTH need not be a power of two, so wrap is an explicit compare.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high reset, pointer to 0
//   clr    - synchronous clear, pointer to 0 (has priority over inc)
//   inc    - advance pointer by one
//   ptr    - current pointer value
module fifo_wrap_ptr #(
  parameter int DEPTH = 5,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ONE_C  = PW'(1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST_C) ? '0 : ptr_q + ONE_C;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mode_fifo_gen.sv
// mode_fifo_gen: parametrised synchronous FIFO for AES mode codes (or any
// narrow control word). Circular buffer with explicit occupancy count,
// registered flags, selectable overflow policy, synchronous flush.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   push, din             - write request and data
//   pop                   - read request; data appears on dout next cycle
//   flush                 - synchronous clear of contents (highest priority)
//   dout, dout_valid      - registered read data, one-cycle valid pulse
//   count                 - occupancy 0..DEPTH
//   full, empty, almost_full - registered occupancy flags
//   overflow, underflow   - one-cycle error pulses
module mode_fifo_gen
  import aes_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter bit OVERWRITE = 1'b1,
  parameter int AFULL_THR = DEPTH - 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THR);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             wr_inc, rd_inc, do_pop;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // Decisions use the registered flags so the outputs never depend
  // combinationally on push/pop. A write into a full FIFO is accepted when
  // a pop frees the slot in the same cycle, or always under OVERWRITE where
  // the read pointer is dragged along to discard the oldest entry.
  always_comb begin
    do_pop = pop && !flush && !empty_q;
    wr_inc = push && !flush && (!full_q || pop || OVERWRITE);
    rd_inc = do_pop || (push && !pop && !flush && full_q && OVERWRITE);
  end

  always_comb begin
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    if (flush) begin
      count_d = '0;
    end else begin
      if (wr_inc && !rd_inc) begin
        count_d = count_q + ONE_C;
      end else if (rd_inc && !wr_inc) begin
        count_d = count_q - ONE_C;
      end
      if (do_pop) begin
        dout_d       = mem[rd_ptr];
        dout_valid_d = 1'b1;
      end
      overflow_d  = push && !pop && full_q;
      underflow_d = pop && empty_q;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    afull_d = (count_d >= AFULL_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      afull_q      <= afull_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_inc) begin
      mem[wr_ptr] <= din;
    end
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (rd_inc),
    .ptr   (rd_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (wr_inc),
    .ptr   (wr_ptr)
  );

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= DEPTH_C);
  a_full_empty: assert property (@(posedge clk) disable iff (reset)
    !(full_q && empty_q));
  a_valid_src: assert property (@(posedge clk) disable iff (reset)
    dout_valid_q |-> $past(pop && !flush && (count_q != '0)));

endmodule

// File: doc/mode_fifo_gen.md
# mode_fifo_gen

Parametrised synchronous FIFO buffering per-block AES key-size mode codes (or any narrow control word) between the input interface and the AES-256 core control path. Generalises the fixed 5-entry, 2-bit mode queue to configurable width and depth, with circular-buffer pointers, true full/empty/almost-full flags, defined simultaneous push/pop behaviour, selectable overflow policy, synchronous flush and error pulses.

## Interface
- WIDTH, 2, entry width in bits (≥1)
- DEPTH, 5, number of entries (≥2, need not be a power of two)
- OVERWRITE, 1, 1 = push when full drops oldest entry; 0 = push when full is rejected
- AFULL_THR, DEPTH-1, almost_full asserts when count ≥ AFULL_THR (1..DEPTH)
- CW (localparam), $clog2(DEPTH+1), count width

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all control state
- push  in  1  write din this cycle
- din  in  WIDTH  entry to write
- pop  in  1  read oldest entry this cycle
- flush  in  1  synchronous clear of contents
- dout  out  WIDTH  registered read data
- dout_valid  out  1  one-cycle pulse: dout holds a freshly popped entry
- count  out  CW  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THR
- overflow  out  1  one-cycle pulse: push while full (dropped-oldest or rejected)
- underflow  out  1  one-cycle pulse: pop while empty

## Operation
- Storage: DEPTH×WIDTH array, rd_ptr/wr_ptr wrap DEPTH-1 → 0 (no power-of-two masking); count held explicitly.
- Storage array not reset; all outputs and pointers are.
- Reset values: dout=0, dout_valid=0, count=0, full=0, empty=1, almost_full=0, overflow=0, underflow=0, rd_ptr=wr_ptr=0.
- Priority per cycle: flush > push/pop. Flush: pointers and count to 0, dout_valid=0, overflow/underflow=0; push/pop that cycle ignored; dout retains value.
- Push only, not full: mem[wr_ptr]←din, wr_ptr++, count++.
- Pop only, not empty: dout←mem[rd_ptr], dout_valid=1, rd_ptr++, count--.
- Push+pop, 0<count<DEPTH: both performed, count unchanged.
- Push+pop, empty: no fall-through; push accepted (count→1), pop ignored, underflow=1, dout_valid=0.
- Push+pop, full: both performed (either OVERWRITE), count stays DEPTH, overflow=0.
- Push only, full, OVERWRITE=1: mem[wr_ptr]←din, wr_ptr++, rd_ptr++ (oldest lost), count stays DEPTH, overflow=1.
- Push only, full, OVERWRITE=0: din discarded, no state change, overflow=1.
- Pop only, empty: no state change, dout holds, underflow=1.
- Flags full/empty/almost_full derived from registered next count (registered outputs, no combinational path from push/pop).

## Timing
- Write latency: entry pushed in cycle N is poppable in cycle N+1.
- Read latency: pop in cycle N → dout/dout_valid valid after edge N+1, for one cycle of dout_valid; dout holds until next successful pop.
- count and flags reflect all operations of cycle N after edge N+1.
- overflow/underflow are single-cycle pulses aligned with the offending edge's update.
- Reset asserted mid-operation: outputs at reset values immediately (async); first push allowed the cycle after reset deasserts.
- Back-to-back pushes/pops at full rate: one per cycle each, no bubbles.

## Structure
- Shared package aes_pkg: typedef for mode code (2-bit: AES128=0, AES192=1, AES256=2, NONE=3), default FIFO_DEPTH and FIFO_WIDTH constants; mode_fifo_gen defaults WIDTH from it.
- One sub-module: fifo_wrap_ptr (parameter DEPTH; inputs clk, reset, clr, inc; output ptr) instantiated for rd_ptr and wr_ptr.
- Assertions (simulation only): count ≤ DEPTH; full and empty never both high; dout_valid implies prior-cycle pop with count>0.

## Test plan
- Reset then push 1,2,3 (WIDTH=2, DEPTH=5), pop ×3 → dout 1,2,3 on consecutive cycles, dout_valid high 3 cycles, empty=1, count=0.
- Fill 5 entries 0,1,2,3,0; push 2 with OVERWRITE=1 → overflow pulse, count=5; pop ×5 → 1,2,3,0,2.
- Same with OVERWRITE=0 → overflow pulse, pop ×5 → 0,1,2,3,0; full high until first pop.
- Empty FIFO, push 3 + pop same cycle → underflow pulse, count=1, next pop returns 3; then push+pop with count=2 for 10 cycles → count stays 2, order preserved through wrap (pointers pass 4→0 twice).
- Count 4 with AFULL_THR=4 → almost_full=1; flush with push high → count=0, empty=1, almost_full=0, pushed value absent.
- Assert reset mid-stream with count=3 and dout_valid high → all outputs to reset values same cycle; after release, pop → underflow=1.
